// File: rtl/hash_block_assembler.sv
// hash_block_assembler: packs a byte stream into NUM_BLOCOS-byte blocks for the
// 8-bit XOR fold hash stage. The first byte of a block lands in the most
// significant lane, and the final block of a message is flagged with out_last.
// Build macro HASH_ASM_PAD_EN enables 0x80 marker plus length-byte padding,
// which may add one extra block; without it, partial blocks are zero-filled.
module hash_block_assembler #(
    parameter int NUM_BLOCOS = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              in_byte,
    input  logic                    in_valid,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic [NUM_BLOCOS*8-1:0] out_block,
    output logic                    out_valid,
    output logic                    out_last,
    input  logic                    out_ready
);
    localparam int W  = NUM_BLOCOS * 8;
    localparam int IW = $clog2(NUM_BLOCOS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BLOCOS - 1);
`ifdef HASH_ASM_PAD_EN
    // Highest last-byte index that still leaves room for the length byte
    localparam logic [IW-1:0] LEN_ROOM = IW'(NUM_BLOCOS - 3);
`endif

    typedef enum logic [1:0] {
        FILL,
        PAD,
        FULL,
        PAD2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [IW-1:0] idx;
    logic [IW-1:0] last_idx;
    logic [W-1:0]  block;
    logic [W-1:0]  fill_block;
    logic [W-1:0]  pad_block;
    logic          accept;
`ifdef HASH_ASM_PAD_EN
    logic [7:0]    msg_len;
    logic          pad2_pending;
    logic [W-1:0]  pad2_block;
`endif

    // Return blk with byte lane 'lane' (lane 0 = most significant) replaced by value
    function automatic logic [W-1:0] set_lane(input logic [W-1:0]  blk,
                                              input logic [IW-1:0] lane,
                                              input logic [7:0]    value);
        logic [W-1:0] res;
        res = blk;
        for (int i = 0; i < NUM_BLOCOS; i++) begin
            if (lane == IW'(i)) begin
                res[(NUM_BLOCOS-1-i)*8 +: 8] = value;
            end
        end
        return res;
    endfunction

    // Return blk with every lane after index k forced to zero
    function automatic logic [W-1:0] zero_above(input logic [W-1:0]  blk,
                                                input logic [IW-1:0] k);
        logic [W-1:0] res;
        res = blk;
        for (int i = 0; i < NUM_BLOCOS; i++) begin
            if (IW'(i) > k) begin
                res[(NUM_BLOCOS-1-i)*8 +: 8] = 8'h00;
            end
        end
        return res;
    endfunction

    assign accept    = in_valid && in_ready;
    assign in_ready  = (state == FILL);
    assign out_valid = (state == FULL);
    assign out_block = block;

    // Candidate block contents for a byte write, the pad step and the extra pad block
    always_comb begin
        fill_block = set_lane(block, idx, in_byte);
        pad_block  = zero_above(block, last_idx);
`ifdef HASH_ASM_PAD_EN
        if (last_idx != LAST_IDX) begin
            pad_block = set_lane(pad_block, last_idx + IW'(1), 8'h80);
        end
        if (last_idx <= LEN_ROOM) begin
            pad_block = set_lane(pad_block, LAST_IDX, msg_len);
        end
        pad2_block = '0;
        if (last_idx == LAST_IDX) begin
            pad2_block = set_lane(pad2_block, '0, 8'h80);
        end
        pad2_block = set_lane(pad2_block, LAST_IDX, msg_len);
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: fill, optional pad step(s), then hold until consumed
    always_comb begin
        next_state = state;
        case (state)
            FILL: begin
                if (accept) begin
                    if (in_last) begin
`ifdef HASH_ASM_PAD_EN
                        next_state = PAD;
`else
                        next_state = (idx == LAST_IDX) ? FULL : PAD;
`endif
                    end else if (idx == LAST_IDX) begin
                        next_state = FULL;
                    end
                end
            end
            PAD: begin
                next_state = FULL;
            end
            FULL: begin
                if (out_ready) begin
`ifdef HASH_ASM_PAD_EN
                    next_state = pad2_pending ? PAD2 : FILL;
`else
                    next_state = FILL;
`endif
                end
            end
            PAD2: begin
                next_state = FULL;
            end
            default: begin
                next_state = FILL;
            end
        endcase
    end

    // Block register, byte index, out_last flag and message length bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            last_idx <= '0;
            block    <= '0;
            out_last <= 1'b0;
`ifdef HASH_ASM_PAD_EN
            msg_len      <= 8'd0;
            pad2_pending <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        block    <= fill_block;
                        idx      <= idx + IW'(1);
                        last_idx <= idx;
`ifdef HASH_ASM_PAD_EN
                        msg_len  <= msg_len + 8'd1;
`endif
                        if (idx == LAST_IDX && !in_last) begin
                            out_last <= 1'b0;
                        end
`ifndef HASH_ASM_PAD_EN
                        if (idx == LAST_IDX && in_last) begin
                            out_last <= 1'b1;
                        end
`endif
                    end
                end
                PAD: begin
                    block <= pad_block;
`ifdef HASH_ASM_PAD_EN
                    if (last_idx <= LEN_ROOM) begin
                        out_last <= 1'b1;
                    end else begin
                        out_last     <= 1'b0;
                        pad2_pending <= 1'b1;
                    end
`else
                    out_last <= 1'b1;
`endif
                end
                FULL: begin
                    if (out_ready) begin
                        idx   <= '0;
                        block <= '0;
`ifdef HASH_ASM_PAD_EN
                        if (out_last) begin
                            msg_len <= 8'd0;
                        end
`endif
                    end
                end
`ifdef HASH_ASM_PAD_EN
                PAD2: begin
                    block        <= pad2_block;
                    out_last     <= 1'b1;
                    pad2_pending <= 1'b0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hash_block_assembler.sv
// tb_hash_block_assembler: table vectors, hand-written corner sequences and
// randomized messages checked against a message-level block model.
module tb_hash_block_assembler;
    localparam int N = 64;
    localparam int W = N * 8;

    typedef logic [7:0] bq_t[$];

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } blk_t;

    typedef struct {
        int         len;
        logic [7:0] start;
        int         nblk;
        logic [7:0] l0;
        logic [7:0] l1;
        logic [7:0] l63;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [W-1:0] out_block;
    logic         out_valid;
    logic         out_last;
    logic         out_ready = 1'b1;

    int   checks = 0;
    int   failures = 0;
    int   ready_mode = 0;
    bit   timed_out = 0;
    blk_t exp_q[$];
    blk_t got_q[$];

    hash_block_assembler #(.NUM_BLOCOS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_block (out_block),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Downstream ready: 0 = always ready, 1 = stall, 2 = random
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Capture every block the downstream consumes
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_q.push_back({out_block, out_last});
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] lane(input logic [W-1:0] d, input int j);
        return d[(N-1-j)*8 +: 8];
    endfunction

    // Reference: expected blocks for a whole message, from the padding rules
    function automatic void model(input bq_t msg);
        blk_t b;
        int   n;
        int   k;
        n = msg.size();
        for (int c = 0; c < n; c += N) begin
            b = '0;
            for (int j = 0; j < N && c + j < n; j++) begin
                b.data[(N-1-j)*8 +: 8] = msg[c+j];
            end
            b.last = (c + N >= n);
`ifdef HASH_ASM_PAD_EN
            if (b.last) begin
                k = (n - 1) % N;
                if (k < N - 1) b.data[(N-2-k)*8 +: 8] = 8'h80;
                if (k <= N - 3) begin
                    b.data[7:0] = 8'(n);
                    exp_q.push_back(b);
                end else begin
                    b.last = 1'b0;
                    exp_q.push_back(b);
                    b = '0;
                    if (k == N - 1) b.data[W-1 -: 8] = 8'h80;
                    b.data[7:0] = 8'(n);
                    b.last = 1'b1;
                    exp_q.push_back(b);
                end
            end else begin
                exp_q.push_back(b);
            end
`else
            k = 0;
            exp_q.push_back(b);
`endif
        end
    endfunction

    task automatic check_output(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Hold the current byte until the DUT takes it
    task automatic wait_accept();
        bit acc;
        int t;
        acc = 0;
        t = 0;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
            if (!acc && t > 4000) begin
                checks++;
                failures++;
                $display("[TB] FAIL accept_timeout actual=stalled required=accept");
                timed_out = 1;
                return;
            end
        end
    endtask

    task automatic apply_stimulus(input bq_t msg, input bit gaps, input bit with_last);
        for (int i = 0; i < msg.size(); i++) begin
            if (timed_out) break;
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    in_valid = 1'b0;
                    in_last  = 1'($urandom_range(0, 1));
                    in_byte  = 8'($urandom);
                    @(posedge clk);
                    #1;
                end
            end
            in_valid = 1'b1;
            in_byte  = msg[i];
            in_last  = with_last && (i == msg.size() - 1);
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Drain the blocks of the current message and compare with the model
    task automatic finish_message(output blk_t last_b, output int nblk);
        int t;
        int n_exp;
        t = 0;
        n_exp = exp_q.size();
        last_b = '0;
        while (got_q.size() < n_exp && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (3) @(posedge clk);
        #1;
        nblk = got_q.size();
        check_output("block_count", W'(got_q.size()), W'(n_exp));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            blk_t g;
            blk_t e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_output("block_data", g.data, e.data);
            check_output("block_last", W'(g.last), W'(e.last));
            last_b = g;
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_valid();
        int t;
        t = 0;
        while (!out_valid && t < 400) begin
            @(negedge clk);
            t++;
        end
        check_output("wait_out_valid", W'(out_valid), W'(1));
    endtask

    initial begin
        vec_t vecs[6];
        bq_t  msg;
        blk_t lb;
        int   nb;
        logic [W-1:0] exp_abc;

`ifdef HASH_ASM_PAD_EN
        vecs[0] = '{len:1,   start:8'h11, nblk:1, l0:8'h11, l1:8'h80, l63:8'h01};
        vecs[1] = '{len:64,  start:8'h00, nblk:2, l0:8'h80, l1:8'h00, l63:8'h40};
        vecs[2] = '{len:65,  start:8'h00, nblk:2, l0:8'h40, l1:8'h80, l63:8'h41};
        vecs[3] = '{len:130, start:8'h00, nblk:3, l0:8'h80, l1:8'h81, l63:8'h82};
        vecs[4] = '{len:63,  start:8'h10, nblk:2, l0:8'h00, l1:8'h00, l63:8'h3F};
        vecs[5] = '{len:300, start:8'h00, nblk:5, l0:8'h00, l1:8'h01, l63:8'h2C};
        exp_abc = {24'hAABBCC, 8'h80, {(W-40){1'b0}}, 8'h03};
`else
        vecs[0] = '{len:1,   start:8'h11, nblk:1, l0:8'h11, l1:8'h00, l63:8'h00};
        vecs[1] = '{len:64,  start:8'h00, nblk:1, l0:8'h00, l1:8'h01, l63:8'h3F};
        vecs[2] = '{len:65,  start:8'h00, nblk:2, l0:8'h40, l1:8'h00, l63:8'h00};
        vecs[3] = '{len:130, start:8'h00, nblk:3, l0:8'h80, l1:8'h81, l63:8'h00};
        vecs[4] = '{len:63,  start:8'h10, nblk:1, l0:8'h10, l1:8'h11, l63:8'h00};
        vecs[5] = '{len:300, start:8'h00, nblk:5, l0:8'h00, l1:8'h01, l63:8'h00};
        exp_abc = {24'hAABBCC, {(W-24){1'b0}}};
`endif

        // Reset values
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_byte  = 8'h00;
        #1;
        check_output("reset_in_ready", W'(in_ready), W'(1));
        check_output("reset_out_valid", W'(out_valid), W'(0));
        check_output("reset_out_last", W'(out_last), W'(0));
        check_output("reset_out_block", out_block, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Full 64-byte message: out_valid one cycle after the final accept
        $display("[TB] full block latency");
        msg.delete();
        for (int i = 0; i < N; i++) msg.push_back(8'(i));
        model(msg);
        apply_stimulus(msg, 0, 1);
`ifdef HASH_ASM_PAD_EN
        check_output("full_latency_valid", W'(out_valid), W'(0));
`else
        check_output("full_latency_valid", W'(out_valid), W'(1));
`endif
        finish_message(lb, nb);

        // Short message: out_valid two cycles after the last accept, then stall
        $display("[TB] short message with stalled downstream");
        ready_mode = 1;
        msg = '{8'hAA, 8'hBB, 8'hCC};
        model(msg);
        apply_stimulus(msg, 0, 1);
        check_output("short_latency_pad", W'(out_valid), W'(0));
        wait_valid();
        in_valid = 1'b1;
        in_byte  = 8'h55;
        in_last  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output("hold_block", out_block, exp_abc);
            check_output("hold_last", W'(out_last), W'(1));
            check_output("hold_in_ready", W'(in_ready), W'(0));
        end
        ready_mode = 0;
        wait_accept();
        in_valid = 1'b0;
        in_last  = 1'b0;
        msg = '{8'h55};
        model(msg);
        finish_message(lb, nb);
        check_output("after_hold_lane0", W'(lane(lb.data, 0)), W'(8'h55));
        check_output("after_hold_lane1", W'(lane(lb.data, 1)), W'(8'h00));

        // Reset in the middle of filling a block
        $display("[TB] reset mid-fill");
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'(8'hF0 + i));
        apply_stimulus(msg, 0, 0);
        rst_n = 1'b0;
        #1;
        check_output("midfill_rst_valid", W'(out_valid), W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("midfill_in_ready", W'(in_ready), W'(1));
        check_output("midfill_out_valid", W'(out_valid), W'(0));
        got_q.delete();
        msg = '{8'hA1, 8'hA2};
        model(msg);
        apply_stimulus(msg, 0, 1);
        finish_message(lb, nb);
        check_output("after_rst_lane0", W'(lane(lb.data, 0)), W'(8'hA1));
        check_output("after_rst_lane1", W'(lane(lb.data, 1)), W'(8'hA2));
`ifdef HASH_ASM_PAD_EN
        check_output("after_rst_len", W'(lane(lb.data, 63)), W'(8'h02));
`else
        check_output("after_rst_lane63", W'(lane(lb.data, 63)), W'(8'h00));
`endif

        // Reset while a block is presented: out_valid drops without a clock edge
        $display("[TB] reset while full");
        ready_mode = 1;
        msg = '{8'h01, 8'h02, 8'h03};
        apply_stimulus(msg, 0, 1);
        wait_valid();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("full_rst_valid", W'(out_valid), W'(0));
        check_output("full_rst_block", out_block, '0);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();

        // Table-driven messages of start+i bytes
        $display("[TB] table vectors");
        for (int v = 0; v < 6; v++) begin
            msg.delete();
            for (int i = 0; i < vecs[v].len; i++) msg.push_back(8'(vecs[v].start + 8'(i)));
            model(msg);
            apply_stimulus(msg, 0, 1);
            finish_message(lb, nb);
            check_output("vec_nblk", W'(nb), W'(vecs[v].nblk));
            check_output("vec_lane0", W'(lane(lb.data, 0)), W'(vecs[v].l0));
            check_output("vec_lane1", W'(lane(lb.data, 1)), W'(vecs[v].l1));
            check_output("vec_lane63", W'(lane(lb.data, 63)), W'(vecs[v].l63));
        end

        // Randomized messages with idle gaps and random backpressure
        $display("[TB] random messages");
        ready_mode = 2;
        for (int m = 0; m < 25; m++) begin
            int len;
            len = $urandom_range(1, 300);
            msg.delete();
            for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
            model(msg);
            apply_stimulus(msg, 1, 1);
            finish_message(lb, nb);
        end
        ready_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hash_block_assembler.md
Name: hash_block_assembler

Overview:
- Upstream feeder of the 8-bit XOR fold hash stage.
- Collects a byte stream into one NUM_BLOCOS-byte block and presents it to the hash stage's 512-bit input through a valid/ready handshake.
- The first byte of a block is placed in the most significant byte lane. Partial final blocks are padded.
- Long messages are split into consecutive blocks; the final block is flagged.

Parameters:
- NUM_BLOCOS, 64, bytes per block. The output block width is NUM_BLOCOS*8. The minimum supported value is 4.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous reset, active low.
- in_byte  input  8  stream data byte.
- in_valid  input  1  in_byte is valid.
- in_last  input  1  in_byte is the final byte of the message.
- in_ready  output  1  the assembler accepts a byte this cycle.
- out_block  output  NUM_BLOCOS*8  assembled block; connects to the hash stage input.
- out_valid  output  1  out_block is complete and held stable.
- out_last  output  1  this block is the final block of the message.
- out_ready  input  1  downstream consumes the block.

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset values: state=FILL, byte index idx=0, block register all zero, msg_len=0, out_valid=0, out_last=0. in_ready reads 1 out of reset.
- Byte accept condition: in_valid && in_ready.
- Byte placement: the byte at index idx is written to out_block[NUM_BLOCOS*8-1-8*idx -: 8]. idx increments on each accept.
- msg_len is an 8-bit counter of accepted bytes in the current message, including the last byte, modulo 256.
- in_ready = (state==FILL). This is combinational from the state register.
- out_valid = (state==FULL). It is registered via the state.
- FILL state transitions on an accept:
  - Accept with idx==NUM_BLOCOS-1 and in_last=0: go to FULL, out_last=0.
  - Accept with in_last=1 and idx==NUM_BLOCOS-1, macro off: go to FULL, out_last=1.
  - Accept with in_last=1, otherwise: go to PAD.
- PAD state: takes exactly one cycle. All byte lanes at index > last-written index become 0x00; see the optional feature for pad content. Then go to FULL with out_last=1.
- FULL state:
  - out_block and out_last are held stable. No bytes are accepted.
  - On out_ready=1: go to FILL, idx=0, block register cleared to zero.
  - If out_last was 1, msg_len is also cleared to 0.
- Timing and throughput:
  - Latency: out_valid rises on the cycle after the 64th accept, or 2 cycles after a short last byte (via PAD).
  - Minimum block period is NUM_BLOCOS+1 cycles. There is no bypass, so a block cannot be emitted and a byte accepted in the same cycle.
- Edge cases:
  - in_last is ignored when in_valid=0.
  - out_ready is ignored outside FULL.
  - An empty message cannot be expressed; in_last always accompanies a byte.
- Reset mid-operation: the partial block and msg_len are discarded. out_valid drops asynchronously. The next accepted byte goes to index 0.

Optional Feature:
- Macro: HASH_ASM_PAD_EN.
- Off: padding is zero-fill only. There is never an extra block.
- On: with the last byte at index k:
  - Lane k+1 = 0x80 when k+1 <= NUM_BLOCOS-1.
  - Lane NUM_BLOCOS-1 = msg_len, when k <= NUM_BLOCOS-3.
  - All other lanes are zero.
- On, with k >= NUM_BLOCOS-2 (no room for the length byte):
  - The current block is emitted with out_last=0. It carries 0x80 at lane k+1 if that lane exists.
  - The PAD2 state then builds an extra block: all zero, 0x80 in lane 0 only if it was not yet placed, and lane NUM_BLOCOS-1 = msg_len.
  - The extra block is emitted through FULL with out_last=1. in_ready stays 0 throughout.
  - A last byte at k=NUM_BLOCOS-1 always goes through PAD/PAD2 when the macro is on.

Test Plan:
- 64 bytes 0x00..0x3F, last on the final byte, macro off -> out_block[511:504]=0x00 … [7:0]=0x3F, out_last=1, out_valid rises 1 cycle after the final accept.
- Bytes AA,BB,CC with last -> out_block[511:488]=AABBCC, remaining lanes zero (macro off). Macro on: lane 3=0x80, lane 63=0x03.
- Hold out_ready=0 for 10 cycles while FULL, with in_valid=1 -> out_block and out_last stable, in_ready=0, no byte consumed. Byte 0 of the next block is accepted only after the out_ready pulse.
- Macro on, 63-byte message (k=62) -> block 1: lane 62 data, lane 63=0x80, out_last=0. Block 2: all zero except lane 63=0x3F, out_last=1.
- 130-byte message, values i mod 256 -> three blocks, out_last=0,0,1. Third block: lanes 0-1 = 0x80,0x81, rest zero (macro off).
- Assert rst_n low after 10 accepted bytes -> out_valid=0, in_ready=1 after release. A new 2-byte message lands in lanes 0-1; macro on: length byte = 0x02.
